// File: rtl/scene_draw_pkg.sv
// Shared constants for the scene draw sequencer: state encoding, default widths
// and the drawer slot assignment.
package scene_draw_pkg;

    localparam int unsigned NUM_SPRITES = 4;
    localparam int unsigned X_W         = 9;
    localparam int unsigned Y_W         = 8;
    localparam int unsigned C_W         = 3;

    localparam int unsigned SLOT_TRAINER = 0;
    localparam int unsigned SLOT_POKEMON = 1;
    localparam int unsigned SLOT_HPBAR   = 2;
    localparam int unsigned SLOT_TEXT    = 3;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SELECT = 3'd1;
    localparam logic [2:0] ST_ARM    = 3'd2;
    localparam logic [2:0] ST_RUN    = 3'd3;
    localparam logic [2:0] ST_DRAIN  = 3'd4;
    localparam logic [2:0] ST_FINISH = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_SELECT = ST_SELECT,
        S_ARM    = ST_ARM,
        S_RUN    = ST_RUN,
        S_DRAIN  = ST_DRAIN,
        S_FINISH = ST_FINISH
    } state_e;

endpackage

// File: rtl/scene_draw_sequencer_lowest_bit_select.sv
// Priority encoder: index of the lowest set request bit, plus a valid flag.
module lowest_bit_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     req,
    output logic [IDX_W-1:0] idx_c,
    output logic             valid_c
);

    // Scan high to low so the lowest set bit is the last one written.
    always_comb begin
        idx_c   = '0;
        valid_c = 1'b0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx_c   = IDX_W'(i);
                valid_c = 1'b1;
            end
        end
    end

endmodule

// File: rtl/scene_draw_sequencer.sv
// Walks a mask of sprite drawers lowest-first, enabling one at a time, and
// merges the active drawer's pixels into a single aligned VGA plot stream.
module scene_draw_sequencer
    import scene_draw_pkg::*;
#(
    parameter int unsigned         NUM_SPRITES   = scene_draw_pkg::NUM_SPRITES,
    parameter int unsigned         X_W           = scene_draw_pkg::X_W,
    parameter int unsigned         Y_W           = scene_draw_pkg::Y_W,
    parameter int unsigned         C_W           = scene_draw_pkg::C_W,
    parameter bit                  TRANSP_EN     = 1'b0,
    parameter logic [C_W-1:0]      TRANSP_COLOUR = '1
) (
    input  logic                       clock_all,
    input  logic                       reset_all,
    input  logic                       start,
    input  logic [NUM_SPRITES-1:0]     sprite_mask,
    input  logic [NUM_SPRITES-1:0]     spr_done,
    input  logic [NUM_SPRITES*X_W-1:0] spr_x,
    input  logic [NUM_SPRITES*Y_W-1:0] spr_y,
    input  logic [NUM_SPRITES*C_W-1:0] spr_colour,
    output logic [NUM_SPRITES-1:0]     spr_enable,
    output logic [NUM_SPRITES-1:0]     spr_reset_n,
    output logic                       plot,
    output logic [X_W-1:0]             out_x,
    output logic [Y_W-1:0]             out_y,
    output logic [C_W-1:0]             out_colour,
    output logic                       busy,
    output logic                       frame_done
);

    localparam int unsigned IDX_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;

    state_e                 state;
    logic [NUM_SPRITES-1:0] pending;
    logic [IDX_W-1:0]       idx;
    logic                   v_q;

    logic [IDX_W-1:0]       sel_idx_c;
    logic                   sel_valid_c;
    logic [NUM_SPRITES-1:0] sel_onehot_c;
    logic [NUM_SPRITES-1:0] idx_onehot_c;
    logic [X_W-1:0]         cur_x_c;
    logic [Y_W-1:0]         cur_y_c;
    logic [C_W-1:0]         cur_col_c;
    logic                   cur_done_c;

    lowest_bit_select #(
        .N     (NUM_SPRITES),
        .IDX_W (IDX_W)
    ) u_sel (
        .req     (pending),
        .idx_c   (sel_idx_c),
        .valid_c (sel_valid_c)
    );

    // Active-slot mux and one-hot decodes.
    always_comb begin
        sel_onehot_c = '0;
        idx_onehot_c = '0;
        cur_x_c      = '0;
        cur_y_c      = '0;
        cur_col_c    = '0;
        cur_done_c   = 1'b0;
        sel_onehot_c[sel_idx_c] = 1'b1;
        idx_onehot_c[idx]       = 1'b1;
        for (int unsigned i = 0; i < NUM_SPRITES; i++) begin
            if (IDX_W'(i) == idx) begin
                cur_x_c    = spr_x[i*X_W +: X_W];
                cur_y_c    = spr_y[i*Y_W +: Y_W];
                cur_col_c  = spr_colour[i*C_W +: C_W];
                cur_done_c = spr_done[i];
            end
        end
    end

    // Colour comes straight from the drawer ROM, which already lags x/y by a cycle.
    assign out_colour  = cur_col_c;
    assign plot        = v_q && (!TRANSP_EN || (cur_col_c != TRANSP_COLOUR));
    assign spr_reset_n = {NUM_SPRITES{reset_all}} & ~((state == S_ARM) ? idx_onehot_c : '0);

    always_ff @(posedge clock_all or negedge reset_all) begin
        if (!reset_all) begin
            state      <= S_IDLE;
            pending    <= '0;
            idx        <= '0;
            v_q        <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            spr_enable <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            v_q        <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pending <= sprite_mask;
                        busy    <= 1'b1;
                        state   <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (!sel_valid_c) begin
                        frame_done <= 1'b1;
                        state      <= S_FINISH;
                    end else begin
                        idx     <= sel_idx_c;
                        pending <= pending & ~sel_onehot_c;
                        state   <= S_ARM;
                    end
                end
                S_ARM: begin
                    spr_enable <= idx_onehot_c;
                    state      <= S_RUN;
                end
                S_RUN: begin
                    out_x <= cur_x_c;
                    out_y <= cur_y_c;
                    v_q   <= 1'b1;
                    if (cur_done_c) begin
                        spr_enable <= '0;
                        state      <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    state <= S_SELECT;
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    spr_enable <= '0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scene_draw_sequencer.sv
// Bench for scene_draw_sequencer: behavioural drawers plus a per-cycle timeline
// model of the plot stream, enables, drawer clears, busy and frame_done.
module tb_scene_draw_sequencer;

    localparam int NS = 4;
    localparam int XW = 9;
    localparam int YW = 8;
    localparam int CW = 3;

    logic clock_all = 1'b0;
    logic reset_all;
    always #5 clock_all = ~clock_all;

    logic              start;
    logic [NS-1:0]     sprite_mask;
    logic [NS-1:0]     spr_done;
    logic [NS*XW-1:0]  spr_x;
    logic [NS*YW-1:0]  spr_y;
    logic [NS*CW-1:0]  spr_colour;
    logic [NS-1:0]     spr_enable;
    logic [NS-1:0]     spr_reset_n;
    logic              plot;
    logic [XW-1:0]     out_x;
    logic [YW-1:0]     out_y;
    logic [CW-1:0]     out_colour;
    logic              busy;
    logic              frame_done;

    scene_draw_sequencer dut (
        .clock_all   (clock_all),
        .reset_all   (reset_all),
        .start       (start),
        .sprite_mask (sprite_mask),
        .spr_done    (spr_done),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .spr_colour  (spr_colour),
        .spr_enable  (spr_enable),
        .spr_reset_n (spr_reset_n),
        .plot        (plot),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_colour  (out_colour),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    // Second instance with the colour key enabled.
    logic              t_start;
    logic [NS-1:0]     t_done;
    logic [NS*XW-1:0]  t_x;
    logic [NS*YW-1:0]  t_y;
    logic [NS*CW-1:0]  t_col;
    logic [NS-1:0]     t_en;
    logic [NS-1:0]     t_rstn;
    logic              t_plot;
    logic [XW-1:0]     t_ox;
    logic [YW-1:0]     t_oy;
    logic [CW-1:0]     t_oc;
    logic              t_busy;
    logic              t_fd;

    scene_draw_sequencer #(
        .TRANSP_EN     (1'b1),
        .TRANSP_COLOUR (3'b111)
    ) dut_t (
        .clock_all   (clock_all),
        .reset_all   (reset_all),
        .start       (t_start),
        .sprite_mask (4'b0001),
        .spr_done    (t_done),
        .spr_x       (t_x),
        .spr_y       (t_y),
        .spr_colour  (t_col),
        .spr_enable  (t_en),
        .spr_reset_n (t_rstn),
        .plot        (t_plot),
        .out_x       (t_ox),
        .out_y       (t_oy),
        .out_colour  (t_oc),
        .busy        (t_busy),
        .frame_done  (t_fd)
    );

    int checks = 0;
    int errors = 0;

    // ROM contents of the behavioural drawers.
    function automatic logic [CW-1:0] pix_col(input int s, input int p);
        return CW'(p) ^ CW'(s);
    endfunction

    // Behavioural raster drawers: clear on spr_reset_n, step while enabled.
    int dw [NS] = '{1, 1, 1, 1};
    int dh [NS] = '{1, 1, 1, 1};
    int cx [NS] = '{0, 0, 0, 0};
    int cy [NS] = '{0, 0, 0, 0};
    logic [CW-1:0] rq [NS];

    always @(posedge clock_all) begin
        for (int i = 0; i < NS; i++) begin
            if (!spr_reset_n[i]) begin
                cx[i] <= 0;
                cy[i] <= 0;
            end else if (spr_enable[i]) begin
                if (cx[i] == dw[i] - 1) begin
                    cx[i] <= 0;
                    cy[i] <= (cy[i] == dh[i] - 1) ? 0 : cy[i] + 1;
                end else begin
                    cx[i] <= cx[i] + 1;
                end
            end
            rq[i] <= pix_col(i, cy[i] * dw[i] + cx[i]);
        end
    end

    always_comb begin
        spr_x      = '0;
        spr_y      = '0;
        spr_colour = '0;
        spr_done   = '0;
        for (int i = 0; i < NS; i++) begin
            spr_x[i*XW +: XW]      = XW'(cx[i]);
            spr_y[i*YW +: YW]      = YW'(cy[i]);
            spr_colour[i*CW +: CW] = rq[i];
            spr_done[i]            = (cx[i] == dw[i] - 1) && (cy[i] == dh[i] - 1);
        end
    end

    // 4x1 keyed drawer on slot 0 of the second instance.
    logic [CW-1:0] tcol_rom [4] = '{3'd7, 3'd2, 3'd7, 3'd1};
    int            tcx = 0;
    logic [CW-1:0] trq;

    always @(posedge clock_all) begin
        if (!t_rstn[0]) tcx <= 0;
        else if (t_en[0]) tcx <= (tcx == 3) ? 0 : tcx + 1;
        trq <= tcol_rom[tcx];
    end

    always_comb begin
        t_x   = '0;
        t_y   = '0;
        t_col = '0;
        t_done = '0;
        t_x[XW-1:0] = XW'(tcx);
        t_col[CW-1:0] = trq;
        t_done[0] = (tcx == 3);
    end

    logic [XW-1:0] t_px [$];
    logic [YW-1:0] t_py [$];
    logic [CW-1:0] t_pc [$];
    always @(negedge clock_all) begin
        if (t_plot === 1'b1) begin
            t_px.push_back(t_ox);
            t_py.push_back(t_oy);
            t_pc.push_back(t_oc);
        end
    end

    // Expected per-cycle outputs, one entry per cycle after the start edge.
    typedef struct packed {
        logic          plot;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [CW-1:0] col;
        logic [NS-1:0] en;
        logic [NS-1:0] rstn;
        logic          busy;
        logic          fd;
    } exp_t;

    exp_t exp_q [$];

    function automatic exp_t idle_e(input logic b);
        exp_t e;
        e.plot = 1'b0;
        e.x    = '0;
        e.y    = '0;
        e.col  = '0;
        e.en   = '0;
        e.rstn = '1;
        e.busy = b;
        e.fd   = 1'b0;
        return e;
    endfunction

    // Each sprite: select, arm, one silent enable cycle, then one plot per pixel.
    task automatic build_timeline(input logic [NS-1:0] m);
        exp_t e;
        int   n;
        for (int s = 0; s < NS; s++) begin
            if (m[s]) begin
                n = dw[s] * dh[s];
                exp_q.push_back(idle_e(1'b1));
                e = idle_e(1'b1);
                e.rstn[s] = 1'b0;
                exp_q.push_back(e);
                e = idle_e(1'b1);
                e.en[s] = 1'b1;
                exp_q.push_back(e);
                for (int p = 0; p < n; p++) begin
                    e = idle_e(1'b1);
                    e.en[s] = (p < n - 1);
                    e.plot  = 1'b1;
                    e.x     = XW'(p % dw[s]);
                    e.y     = YW'(p / dw[s]);
                    e.col   = pix_col(s, p);
                    exp_q.push_back(e);
                end
            end
        end
        exp_q.push_back(idle_e(1'b1));
        e = idle_e(1'b1);
        e.fd = 1'b1;
        exp_q.push_back(e);
        exp_q.push_back(idle_e(1'b0));
        exp_q.push_back(idle_e(1'b0));
    endtask

    int cyc, model_n;
    int obs_plots, obs_first, obs_gap, zrun, obs_fd, obs_fd_cyc, obs_busy, obs_arm, obs_overlap;
    logic [XW-1:0] obs_lx;
    logic [YW-1:0] obs_ly;
    logic [CW-1:0] obs_lc;

    // Per-cycle compare against the timeline, plus scene statistics.
    always @(negedge clock_all) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cyc++;
            checks++;
            if (plot !== e.plot || spr_enable !== e.en || spr_reset_n !== e.rstn ||
                busy !== e.busy || frame_done !== e.fd ||
                (e.plot && (out_x !== e.x || out_y !== e.y || out_colour !== e.col))) begin
                errors++;
                if (errors < 20)
                    $display("FAIL cycle %0d: got plot=%b x=%0d y=%0d c=%0d en=%b rstn=%b busy=%b fd=%b, expected plot=%b x=%0d y=%0d c=%0d en=%b rstn=%b busy=%b fd=%b",
                             cyc, plot, out_x, out_y, out_colour, spr_enable, spr_reset_n, busy, frame_done,
                             e.plot, e.x, e.y, e.col, e.en, e.rstn, e.busy, e.fd);
            end
            if (plot === 1'b1) begin
                if (obs_plots == 0) obs_first = cyc;
                else obs_gap += zrun;
                obs_plots++;
                zrun   = 0;
                obs_lx = out_x;
                obs_ly = out_y;
                obs_lc = out_colour;
            end else begin
                zrun++;
            end
            if (frame_done === 1'b1) begin
                obs_fd++;
                obs_fd_cyc = cyc;
            end
            if (busy === 1'b1) obs_busy++;
            if (spr_reset_n !== '1) obs_arm++;
            if ($countones(spr_enable) > 1) obs_overlap++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic launch(input logic [NS-1:0] m, input int repulse);
        @(negedge clock_all);
        start       = 1'b1;
        sprite_mask = m;
        cyc = 0; obs_plots = 0; obs_first = 0; obs_gap = 0; zrun = 0;
        obs_fd = 0; obs_fd_cyc = 0; obs_busy = 0; obs_arm = 0; obs_overlap = 0;
        #1;
        build_timeline(m);
        model_n = exp_q.size();
        @(posedge clock_all);
        #1;
        start       = 1'b0;
        sprite_mask = NS'($urandom);
        if (repulse > 0) begin
            repeat (repulse) @(negedge clock_all);
            start       = 1'b1;
            sprite_mask = '1;
            @(negedge clock_all);
            start = 1'b0;
        end
    endtask

    task automatic wait_done();
        while (exp_q.size() > 0) @(negedge clock_all);
        #1;
    endtask

    initial begin
        reset_all   = 1'b0;
        start       = 1'b0;
        sprite_mask = '0;
        t_start     = 1'b0;

        repeat (3) begin
            @(negedge clock_all);
            chk("reset_outputs", {plot, busy, frame_done, spr_enable, spr_reset_n}, 0);
        end
        reset_all = 1'b1;
        @(negedge clock_all);
        chk("idle_after_reset", {busy, plot, frame_done, spr_enable}, 0);
        chk("rstn_released", spr_reset_n, 4'hF);

        // Full-size trainer sprite, with a stray start pulse mid-draw.
        dw[0] = 63; dh[0] = 59;
        launch(4'b0001, 100);
        chk("model_len_63x59", model_n, 3724);
        wait_done();
        chk("plots_63x59", obs_plots, 3717);
        chk("first_plot_cycle", obs_first, 4);
        chk("last_x", obs_lx, 62);
        chk("last_y", obs_ly, 58);
        chk("last_colour", obs_lc, 4);
        chk("clear_cycles", obs_arm, 1);
        chk("frame_done_pulses", obs_fd, 1);
        chk("frame_done_cycle", obs_fd_cyc, 3722);

        // Empty scene.
        launch(4'b0000, 0);
        wait_done();
        chk("empty_plots", obs_plots, 0);
        chk("empty_fd_cycle", obs_fd_cyc, 2);
        chk("empty_busy_cycles", obs_busy, 2);

        // Two 4x2 sprites in slots 1 and 3.
        dw[1] = 4; dh[1] = 2; dw[3] = 4; dh[3] = 2;
        launch(4'b1010, 0);
        wait_done();
        chk("pair_plots", obs_plots, 16);
        chk("pair_gap", obs_gap, 3);
        chk("pair_overlap", obs_overlap, 0);
        chk("pair_clears", obs_arm, 2);

        // Asynchronous reset while a sprite is being drawn.
        dw[0] = 5; dh[0] = 4;
        launch(4'b0001, 0);
        repeat (9) @(negedge clock_all);
        exp_q.delete();
        #1;
        chk("pre_reset_drawing", {plot, busy}, 2'b11);
        #1;
        reset_all = 1'b0;
        #1;
        chk("async_drop", {plot, busy, frame_done, spr_enable, spr_reset_n}, 0);
        repeat (3) begin
            @(negedge clock_all);
            chk("held_reset", {plot, busy, frame_done, spr_enable, spr_reset_n}, 0);
        end
        reset_all = 1'b1;
        @(negedge clock_all);
        chk("recovered_idle", {busy, plot, spr_enable, spr_reset_n}, 8'h0F);
        launch(4'b0001, 0);
        wait_done();
        chk("recovered_plots", obs_plots, 20);

        // Colour key on the second instance.
        @(negedge clock_all);
        t_start = 1'b1;
        @(negedge clock_all);
        t_start = 1'b0;
        repeat (14) @(negedge clock_all);
        chk("transp_count", t_px.size(), 2);
        if (t_px.size() == 2) begin
            chk("transp_x0", t_px[0], 1);
            chk("transp_c0", t_pc[0], 2);
            chk("transp_x1", t_px[1], 3);
            chk("transp_c1", t_pc[1], 1);
            chk("transp_y", {t_py[0], t_py[1]}, 0);
        end
        chk("transp_idle", t_busy, 0);

        // Random scenes.
        repeat (12) begin
            for (int s = 0; s < NS; s++) begin
                dw[s] = $urandom_range(1, 6);
                dh[s] = $urandom_range(1, 4);
            end
            launch(NS'($urandom_range(0, 15)), 0);
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
